issue_grant_rr16: RTL
=====================

Name: issue_grant_rr16

Overview:
- Round-robin grant generator for the issue stage.
- Consumes a 16-bit ready/request vector, of the kind our 16-input OR reduction collapses to "any ready".
- Expands that vector back out into a registered one-hot grant plus its encoded index.
- Holds each grant under a valid/ready handshake with the downstream issue port.
- Sits between the reservation-station ready logic and the functional-unit dispatch mux.

Parameters:
- N_REQ, 16, number of requestors; fixed at 16 for this revision.
- IDX_W, 4, width of the encoded grant index; equals log2(N_REQ).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  16  request vector; bit i set means entry i is ready to issue.
- grant_ready  input  1  downstream accepts the current grant this cycle.
- lock  input  1  present only with ISSUE_GRANT_LOCK_EN; keeps the grant on the current requestor.
- grant  output  16  one-hot grant; all zero when grant_valid is 0.
- grant_idx  output  4  binary index of the set grant bit; 0 when grant_valid is 0.
- grant_valid  output  1  grant/grant_idx hold a valid offer.
- any_req  output  1  combinational OR of req; independent of state.

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs):
  - grant = 0, grant_idx = 0, grant_valid = 0, ptr = 0, state = IDLE.
  - Reset asserted mid-handshake drops the grant at that edge; no transfer is counted that cycle.
- ptr (4-bit) is the highest-priority position.
  - Selection = first set bit scanning ptr, ptr+1, ... , 15, 0, ... , ptr-1 (modulo 16).
- States:
  - IDLE: grant_valid = 0.
    - If req != 0 at an edge: load the selected requestor into grant/grant_idx, set grant_valid, go to OFFER.
    - Latency from req assertion to grant_valid is exactly 1 cycle.
  - OFFER: grant_valid = 1.
    - While grant_ready = 0: grant and grant_idx stay bit-for-bit stable, even if req changes or the granted bit drops. The grant is sticky; the requestor must not withdraw.
    - Transfer = grant_valid & grant_ready at an edge. On transfer:
      - ptr <= grant_idx + 1 (mod 16; index 15 wraps ptr to 0).
      - Next selection is from (req & ~grant) using the new ptr, so back-to-back grants issue one per cycle.
      - If that masked vector is zero: grant_valid <= 0, state <= IDLE.
- Invariants:
  - grant is always zero or one-hot.
  - grant_idx always matches grant.
  - A requestor held continuously high is granted within 16 transfers (no starvation).
- Simultaneous events: a new req bit arriving on the same edge as a transfer takes part in that edge's selection.
- req = 16'hFFFF held with grant_ready = 1: grant_idx walks 0, 1, 2, ..., 15, 0, ...

Optional Feature:
- Macro: ISSUE_GRANT_LOCK_EN.
- Defined:
  - The lock port exists.
  - A transfer with lock = 1 keeps the same grant and leaves ptr unchanged, provided the granted req bit is still 1 (multi-cycle issue).
  - If lock = 1 but the granted bit is 0, lock is ignored and the normal transfer rule applies.
- Undefined:
  - No lock port.
  - Behaviour identical to the lock = 0 case.

Test Plan:
- Reset release, req = 0 for 5 cycles -> grant_valid = 0, grant = 0, any_req = 0 throughout.
- req = 16'h0010 from cycle 0, grant_ready = 0 -> cycle 1: grant = 16'h0010, grant_idx = 4. This holds for 10 cycles even after req drops to 16'h0000.
- req = 16'hFFFF, grant_ready = 1 for 18 cycles -> grant_idx sequence 0..15 then 0, 1; one grant per cycle, no bubbles.
- ptr = 14 (after a transfer at idx 13), req = 16'h0005 -> next grant_idx = 0, then 2; ptr wraps correctly.
- Reset asserted while OFFER with grant_idx = 7 -> next edge: all outputs 0; with req = 16'h0080 still high, a grant appears one cycle after reset deasserts with grant_idx = 7 and ptr restarted at 0.
- ISSUE_GRANT_LOCK_EN: grant_idx = 3, lock = 1, grant_ready = 1 for 4 cycles with req = 16'h0018 -> grant_idx stays 3. Lock then drops -> grant_idx moves to 4 on the next transfer.

Source files
------------

// File: rtl/issue_grant_rr16.sv
// issue_grant_rr16: round-robin issue grant generator.
// Takes a 16-bit ready/request vector and produces a registered one-hot grant
// with its binary index. Each grant is held under a valid/ready handshake.
// Optional feature macro: ISSUE_GRANT_LOCK_EN adds lock_i, which lets a
// transfer keep the current grant (multi-cycle issue) while its req bit holds.
module issue_grant_rr16 #(
    parameter int N_REQ = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic             grant_ready_i,
`ifdef ISSUE_GRANT_LOCK_EN
    input  logic             lock_i,
`endif
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_valid_o,
    output logic             any_req_o
);

    typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

    typedef struct packed {
        logic [N_REQ-1:0] grant;
        logic [IDX_W-1:0] idx;
    } gnt_t;

    state_t           state_q, state_d;
    gnt_t             gnt_q, gnt_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] scan_vec;
    logic [IDX_W-1:0] scan_ptr;
    logic             hold;

    // First set bit of v scanning from p upward. The index add wraps
    // naturally because N_REQ == 2**IDX_W.
    function automatic gnt_t pick(input logic [N_REQ-1:0] v,
                                  input logic [IDX_W-1:0] p);
        gnt_t             r;
        logic             found;
        logic [IDX_W-1:0] j;
        r     = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            j = p + IDX_W'(k);
            if (!found && v[j]) begin
                found      = 1'b1;
                r.grant    = '0;
                r.grant[j] = 1'b1;
                r.idx      = j;
            end
        end
        return r;
    endfunction

    // Next-state logic: load from IDLE, hold while stalled, re-arbitrate on transfer.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        scan_vec = '0;
        scan_ptr = ptr_q;
`ifdef ISSUE_GRANT_LOCK_EN
        hold     = lock_i & req_i[gnt_q.idx];
`else
        hold     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                scan_vec = req_i;
                scan_ptr = ptr_q;
                if (|req_i) begin
                    gnt_d   = pick(scan_vec, scan_ptr);
                    state_d = OFFER;
                end
            end
            OFFER: begin
                // Grant is sticky until accepted; req changes are ignored here.
                if (grant_ready_i && !hold) begin
                    ptr_d    = gnt_q.idx + IDX_W'(1);
                    // Exclude the just-issued entry so it cannot be re-picked
                    // on the same edge; new arrivals do take part.
                    scan_vec = req_i & ~gnt_q.grant;
                    scan_ptr = ptr_d;
                    if (|scan_vec) begin
                        gnt_d = pick(scan_vec, scan_ptr);
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State, grant and pointer registers; reset wins over any handshake.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant_o       = gnt_q.grant;
    assign grant_idx_o   = gnt_q.idx;
    assign grant_valid_o = (state_q == OFFER);
    assign any_req_o     = |req_i;

endmodule
